// File: rtl/sd_dfc_pkg.sv
// Shared definitions for the delayed-flow-control (DFC) tx/rx pair.
// Provides the burst counter width helper and the tx-side latency
// contribution to the receiver's round-trip budget.
package sd_dfc_pkg;

  // Tx contribution to rx rt_lat: optional c_fc_n flop plus the c_vld flop.
  localparam int DFC_TX_LAT_REG   = 2;
  localparam int DFC_TX_LAT_NOREG = 1;

  function automatic int tx_latency(input int regcin);
    return regcin + 1;
  endfunction

  // clog2(burst_max+1), never below 1 so a disabled limiter still has a legal vector.
  function automatic int bcnt_width(input int burst_max);
    return (burst_max < 1) ? 1 : $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/sd_dfc_tx_buf.sv
// 2-entry skid buffer feeding the DFC transmitter.
// Ports: clk/rst (async high), p_srdy/p_drdy/p_data producer side with
// registered ready, pop (caller guarantees occ != 0), occ occupancy,
// head = oldest entry.
module sd_dfc_tx_buf #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_srdy,
  output logic             p_drdy,
  input  logic [width-1:0] p_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [width-1:0] head
);

  logic [width-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic [1:0]       occ_next;

  assign push = p_srdy & p_drdy;
  assign head = mem[rd_ptr];

  always_comb begin
    occ_next = occ;
    if (push && !pop)      occ_next = occ + 2'd1;
    else if (!push && pop) occ_next = occ - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      p_drdy <= 1'b1;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      occ    <= occ_next;
      // Ready is a flop: look at next occupancy so a full buffer never overflows.
      p_drdy <= (occ_next < 2'd2);
      if (push) begin
        mem[wr_ptr] <= p_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: rtl/sd_dfc_tx_ctl.sv
// Transmit-side srdy/drdy -> delayed flow control converter.
// Ports: clk/rst (async high); p_srdy/p_drdy/p_data producer side;
// c_vld/c_data registered channel out; c_fc_n delayed credit from rx
// (1 = may send); force_stop inhibits sending without loss; stat_clr clears
// stall_cnt; stall_cnt saturating stall cycles; idle = nothing buffered or
// in flight.
module sd_dfc_tx_ctl
  import sd_dfc_pkg::*;
#(
  parameter int width     = 8,
  parameter int regcin    = 1,
  parameter int burst_max = 0,
  parameter int cntsz     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_srdy,
  output logic             p_drdy,
  input  logic [width-1:0] p_data,
  output logic             c_vld,
  output logic [width-1:0] c_data,
  input  logic             c_fc_n,
  input  logic             force_stop,
  input  logic             stat_clr,
  output logic [cntsz-1:0] stall_cnt,
  output logic             idle
);

  localparam int            BW   = bcnt_width(burst_max);
  localparam logic [BW-1:0] BMAX = BW'(burst_max);

  logic             fc_q;
  logic [1:0]       occ;
  logic [width-1:0] head;
  logic [BW-1:0]    bcnt;
  logic             bubble;
  logic             send;
  logic             stall;

  generate
    if (regcin != 0) begin : g_fc_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) fc_q <= 1'b0;
        else     fc_q <= c_fc_n;
      end
    end else begin : g_fc_comb
      assign fc_q = c_fc_n;
    end
  endgenerate

  sd_dfc_tx_buf #(.width(width)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .pop    (send),
    .occ    (occ),
    .head   (head)
  );

  // Limiter forces one idle cycle once burst_max back-to-back sends happened.
  assign bubble = (burst_max != 0) && (bcnt == BMAX);
  assign send   = (occ != 2'd0) & fc_q & ~force_stop & ~bubble;
  // Only receiver back-pressure counts as a stall; local inhibits do not.
  assign stall  = (occ != 2'd0) & ~fc_q & ~force_stop & ~bubble;
  assign idle   = (occ == 2'd0) & ~c_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld  <= 1'b0;
      c_data <= '0;
      bcnt   <= '0;
    end else begin
      c_vld <= send;
      if (send) begin
        c_data <= head;
        bcnt   <= bcnt + BW'(1);
      end else begin
        bcnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            stall_cnt <= '0;
    else if (stat_clr)                  stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + cntsz'(1);
  end

endmodule

// File: tb/tb_sd_dfc_tx_ctl.sv
// Directed bench for sd_dfc_tx_ctl: instance a uses defaults (regcin=1,
// no burst limit, 16-bit stall counter); instance b uses burst_max=3 and a
// 4-bit stall counter.
module tb_sd_dfc_tx_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       p_srdy_a = 1'b0, p_drdy_a, c_vld_a, idle_a;
  logic [7:0] p_data_a = 8'h00, c_data_a;
  logic       c_fc_n_a = 1'b1, force_stop_a = 1'b0, stat_clr_a = 1'b0;
  logic [15:0] stall_cnt_a;

  logic       p_srdy_b = 1'b0, p_drdy_b, c_vld_b, idle_b;
  logic [7:0] p_data_b = 8'h00, c_data_b;
  logic       c_fc_n_b = 1'b1, force_stop_b = 1'b0, stat_clr_b = 1'b0;
  logic [3:0] stall_cnt_b;

  int npass = 0;
  int ntotal = 0;
  int pidx, cidx;
  logic drdy_s, srdy_s;

  always #5 clk = ~clk;

  sd_dfc_tx_ctl #(.width(8), .regcin(1), .burst_max(0), .cntsz(16)) u_a (
    .clk(clk), .rst(rst), .p_srdy(p_srdy_a), .p_drdy(p_drdy_a), .p_data(p_data_a),
    .c_vld(c_vld_a), .c_data(c_data_a), .c_fc_n(c_fc_n_a), .force_stop(force_stop_a),
    .stat_clr(stat_clr_a), .stall_cnt(stall_cnt_a), .idle(idle_a)
  );

  sd_dfc_tx_ctl #(.width(8), .regcin(1), .burst_max(3), .cntsz(4)) u_b (
    .clk(clk), .rst(rst), .p_srdy(p_srdy_b), .p_drdy(p_drdy_b), .p_data(p_data_b),
    .c_vld(c_vld_b), .c_data(c_data_b), .c_fc_n(c_fc_n_b), .force_stop(force_stop_b),
    .stat_clr(stat_clr_b), .stall_cnt(stall_cnt_b), .idle(idle_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_drdy", p_drdy_a, 1);
    chk("rst_vld", c_vld_a, 0);
    chk("rst_data", c_data_a, 0);
    chk("rst_stall", stall_cnt_a, 0);
    chk("rst_idle", idle_a, 1);
    chk("rst_idle_b", idle_b, 1);

    // basic stream: 01,02,03 back to back
    @(negedge clk); rst = 1'b0; p_srdy_a = 1'b1; p_data_a = 8'h01;
    step(); chk("t1_vld_n1", c_vld_a, 0); chk("t1_drdy1", p_drdy_a, 1);
    p_data_a = 8'h02; step();
    chk("t1_vld_n2", c_vld_a, 1); chk("t1_d01", c_data_a, 8'h01); chk("t1_drdy2", p_drdy_a, 1);
    p_data_a = 8'h03; step();
    chk("t1_vld3", c_vld_a, 1); chk("t1_d02", c_data_a, 8'h02); chk("t1_drdy3", p_drdy_a, 1);
    p_srdy_a = 1'b0; step();
    chk("t1_vld4", c_vld_a, 1); chk("t1_d03", c_data_a, 8'h03);
    step(); chk("t1_vld5", c_vld_a, 0); chk("t1_idle", idle_a, 1); chk("t1_stall", stall_cnt_a, 0);

    // flow control drop with words 10..14
    p_srdy_a = 1'b1; p_data_a = 8'h10; step(); chk("t2_vld_f1", c_vld_a, 0);
    p_data_a = 8'h11; step(); chk("t2_vld_f2", c_vld_a, 1); chk("t2_d10", c_data_a, 8'h10);
    p_data_a = 8'h12; c_fc_n_a = 1'b0; step();
    chk("t2_vld_f3", c_vld_a, 1); chk("t2_d11", c_data_a, 8'h11);
    p_data_a = 8'h13; step();
    chk("t2_vld_f4", c_vld_a, 0); chk("t2_stall1", stall_cnt_a, 1); chk("t2_drdy_f4", p_drdy_a, 0);
    p_data_a = 8'h14; step();
    chk("t2_drdy_f5", p_drdy_a, 0); chk("t2_stall2", stall_cnt_a, 2); chk("t2_idle_f5", idle_a, 0);
    step(); chk("t2_stall3", stall_cnt_a, 3); chk("t2_hold", c_data_a, 8'h11);
    c_fc_n_a = 1'b1; step(); chk("t2_vld_f7", c_vld_a, 0); chk("t2_stall4", stall_cnt_a, 4);
    step();
    chk("t2_vld_f8", c_vld_a, 1); chk("t2_d12", c_data_a, 8'h12);
    chk("t2_drdy_f8", p_drdy_a, 1); chk("t2_stall_f8", stall_cnt_a, 4);
    step(); chk("t2_vld_f9", c_vld_a, 1); chk("t2_d13", c_data_a, 8'h13);
    p_srdy_a = 1'b0; step(); chk("t2_vld_f10", c_vld_a, 1); chk("t2_d14", c_data_a, 8'h14);
    step(); chk("t2_vld_f11", c_vld_a, 0); chk("t2_idle", idle_a, 1);

    // force_stop for 4 cycles with 20,21 pending
    force_stop_a = 1'b1; p_srdy_a = 1'b1; p_data_a = 8'h20; step(); chk("t4_vld1", c_vld_a, 0);
    p_data_a = 8'h21; step(); chk("t4_vld2", c_vld_a, 0); chk("t4_drdy", p_drdy_a, 0);
    p_srdy_a = 1'b0; step(); chk("t4_vld3", c_vld_a, 0); chk("t4_stall3", stall_cnt_a, 4);
    step(); chk("t4_vld4", c_vld_a, 0); chk("t4_stall4", stall_cnt_a, 4); chk("t4_hold", c_data_a, 8'h14);
    force_stop_a = 1'b0; step();
    chk("t4_vld5", c_vld_a, 1); chk("t4_d20", c_data_a, 8'h20); chk("t4_drdy5", p_drdy_a, 1);
    step(); chk("t4_vld6", c_vld_a, 1); chk("t4_d21", c_data_a, 8'h21);
    step(); chk("t4_idle", idle_a, 1); chk("t4_stall_end", stall_cnt_a, 4);

    // burst limit 3 on instance b: 12 words 40..4b, pattern 1,1,1,0
    pidx = 0; cidx = 0;
    for (int k = 1; k <= 24; k++) begin
      p_srdy_b = (pidx < 12);
      p_data_b = 8'(32'h40 + pidx);
      srdy_s = p_srdy_b; drdy_s = p_drdy_b;
      step();
      if (srdy_s && drdy_s) pidx++;
      if (k <= 14) chk("t3_vld", c_vld_b, (k >= 2 && ((k - 2) % 4) != 3) ? 1 : 0);
      if (c_vld_b) begin
        chk("t3_data", c_data_b, 32'h40 + cidx);
        cidx++;
      end
    end
    chk("t3_count", cidx, 12);
    chk("t3_idle", idle_b, 1);
    chk("t3_stall", stall_cnt_b, 0);

    // stall counter saturation on 4-bit counter, then stat_clr
    c_fc_n_b = 1'b0; step();
    p_srdy_b = 1'b1; p_data_b = 8'h50; step(); chk("t5_stall0", stall_cnt_b, 0);
    p_srdy_b = 1'b0;
    repeat (14) step();
    chk("t5_stall14", stall_cnt_b, 14);
    step(); chk("t5_stall15", stall_cnt_b, 15);
    repeat (3) step();
    chk("t5_sat", stall_cnt_b, 15); chk("t5_vld_held", c_vld_b, 0);
    stat_clr_b = 1'b1; step(); chk("t5_clr", stall_cnt_b, 0);
    stat_clr_b = 1'b0; step(); chk("t5_after_clr", stall_cnt_b, 1);
    c_fc_n_b = 1'b1; step(); chk("t5_fc_edge", stall_cnt_b, 2); chk("t5_vld_fc", c_vld_b, 0);
    step(); chk("t5_vld", c_vld_b, 1); chk("t5_d50", c_data_b, 8'h50); chk("t5_stall_keep", stall_cnt_b, 2);

    // async reset mid-burst on instance a
    p_srdy_a = 1'b1; p_data_a = 8'h30; step();
    p_data_a = 8'h31; step();
    chk("t6_vld_pre", c_vld_a, 1); chk("t6_d30", c_data_a, 8'h30); chk("t6_idle_pre", idle_a, 0);
    #2; rst = 1'b1; #1;
    chk("t6_vld_rst", c_vld_a, 0); chk("t6_drdy_rst", p_drdy_a, 1);
    chk("t6_idle_rst", idle_a, 1); chk("t6_stall_rst", stall_cnt_a, 0); chk("t6_data_rst", c_data_a, 0);
    p_srdy_a = 1'b0;
    step(); step();
    @(negedge clk); rst = 1'b0; p_srdy_a = 1'b1; p_data_a = 8'hAA;
    step(); chk("t6_vld_r1", c_vld_a, 0);
    p_srdy_a = 1'b0; step();
    chk("t6_vld_r2", c_vld_a, 1); chk("t6_dAA", c_data_a, 8'hAA);
    step(); chk("t6_vld_r3", c_vld_a, 0); chk("t6_idle_end", idle_a, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
